des128_key_schedule: RTL and testbench

Sequential round-key generator for the 128-bit DES expansion. It takes one 128-bit master key and streams the sixteen 96-bit subkeys that feed the F-function key input, one subkey per accepted handshake. It sits directly upstream of the F-function stage, driven by the round controller. It supports both encryption order and decryption (reverse) order.

---
 rtl/des128_key_schedule.sv | 164 ++++++++++++++++
 tb/tb_des128_key_schedule.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des128_key_schedule.sv
// ---------------------------------------------------------------------------
// des128_key_schedule
//
// Sequential round-key generator for the 128-bit DES expansion. It loads one
// 128-bit master key and then presents the sixteen 96-bit subkeys one at a
// time. Each subkey is consumed by a handshake. The subkeys can come out in
// encryption order or in decryption (reverse) order.
//
// Ports
//   clk       in   1    system clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   key_in    in   128  master key, sampled when start is accepted
//   mode      in   1    0 = encrypt order, 1 = decrypt order; sampled on start
//   start     in   1    load request; honoured only in IDLE
//   busy      out  1    high while in RUN
//   sk_valid  out  1    subkey on sk_out is valid
//   sk_ready  in   1    consumer accepts subkey
//   sk_out    out  96   current subkey
//   sk_round  out  4    index of current subkey, 0..15
//   done      out  1    one-cycle pulse after the 16th subkey is accepted
//
// Handshake: a subkey transfers on every rising edge where sk_valid and
// sk_ready are both high. While sk_valid is high and sk_ready is low,
// sk_out, sk_round and the internal C/D registers hold their values.
// sk_valid never drops until its subkey has transferred. The FSM state can
// be observed on busy, which is high exactly when the FSM is in RUN.
// ---------------------------------------------------------------------------
module des128_key_schedule #(
    parameter int ROUNDS = 16,
    parameter int HALF_W = 56,
    parameter int SK_W   = 96
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [127:0]    key_in,
    input  logic            mode,
    input  logic            start,
    output logic            busy,
    output logic            sk_valid,
    input  logic            sk_ready,
    output logic [SK_W-1:0] sk_out,
    output logic [3:0]      sk_round,
    output logic            done
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [HALF_W-1:0]   c_r;
    logic [HALF_W-1:0]   d_r;
    logic [3:0]          round_r;
    logic                mode_r;

    logic [2*HALF_W-1:0] p_key;
    logic [HALF_W-1:0]   c0;
    logic [HALF_W-1:0]   d0;
    logic [4:0]          n_enc;
    logic [4:0]          n_dec;
    logic                handshake;

    // Remove the LSB of every key byte and pack the remaining 7-bit groups
    // with the most significant byte first.
    function automatic logic [2*HALF_W-1:0] pc1(input logic [127:0] k);
        logic [2*HALF_W-1:0] p;
        p = '0;
        for (int j = 0; j < 16; j++) begin
            p[7*j +: 7] = k[8*j+1 +: 7];
        end
        return p;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x,
                                               input int unsigned n);
        return (x << n) | (x >> (HALF_W - n));
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (HALF_W - n));
    endfunction

    // Shift amount for 1-based round n.
    function automatic int unsigned sched(input logic [4:0] n);
        case (n)
            5'd1, 5'd2, 5'd9, 5'd16: return 1;
            default:                 return 2;
        endcase
    endfunction

    assign p_key = pc1(key_in);
    assign c0    = p_key[2*HALF_W-1:HALF_W];
    assign d0    = p_key[HALF_W-1:0];

    // The registers move forward to 1-based round sk_round+2. Decryption
    // walks the same schedule backwards, so it undoes the shift of round
    // 18-n instead.
    assign n_enc = {1'b0, round_r} + 5'd2;
    assign n_dec = 5'd18 - n_enc;

    assign handshake = sk_valid && sk_ready;
    assign sk_out    = {c_r[HALF_W-1:8], d_r[HALF_W-1:8]};
    assign sk_round  = round_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            c_r      <= '0;
            d_r      <= '0;
            round_r  <= '0;
            mode_r   <= 1'b0;
            busy     <= 1'b0;
            sk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        // The decrypt stream starts at the last encrypt
                        // subkey. The total rotation is 28.
                        if (mode) begin
                            c_r <= rotl(c0, 28);
                            d_r <= rotl(d0, 28);
                        end else begin
                            c_r <= rotl(c0, 1);
                            d_r <= rotl(d0, 1);
                        end
                        round_r  <= '0;
                        state    <= RUN;
                        busy     <= 1'b1;
                        sk_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (round_r == LAST_ROUND) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            sk_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            round_r <= round_r + 4'd1;
                            if (mode_r) begin
                                c_r <= rotr(c_r, sched(n_dec));
                                d_r <= rotr(d_r, sched(n_dec));
                            end else begin
                                c_r <= rotl(c_r, sched(n_enc));
                                d_r <= rotl(d_r, sched(n_enc));
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des128_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_des128_key_schedule
//
// Directed bench for des128_key_schedule. A reference model builds the
// expected 16-entry subkey stream for a key and mode. It starts from the
// cumulative shift of each round and applies the reverse order for decrypt.
// A negedge compare process checks every handshake against that stream. It
// also checks that outputs stay stable during stalls and checks the done
// pulse. Hand-computed literals pin the model itself.
// ---------------------------------------------------------------------------
module tb_des128_key_schedule;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         mode = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         sk_valid;
    logic         sk_ready = 1'b1;
    logic [95:0]  sk_out;
    logic [3:0]   sk_round;
    logic         done;

    always #5 clk = ~clk;

    des128_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .mode     (mode),
        .start    (start),
        .busy     (busy),
        .sk_valid (sk_valid),
        .sk_ready (sk_ready),
        .sk_out   (sk_out),
        .sk_round (sk_round),
        .done     (done)
    );

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [95:0] exp_q[$];
    logic [3:0]  exp_rnd_q[$];
    logic [95:0] got_q[$];
    logic [95:0] enc_cap[$];
    bit          mon_en = 1'b0;
    bit          exp_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [95:0] prev_sk = '0;
    logic [3:0]  prev_rnd = '0;

    int sched_tbl[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Walk the key from MSB to LSB and keep every bit that is not a byte LSB.
    function automatic logic [111:0] model_pc1(input logic [127:0] k);
        logic [111:0] p;
        p = '0;
        for (int i = 127; i >= 0; i--) begin
            if (i % 8 != 0) p = {p[110:0], k[i]};
        end
        return p;
    endfunction

    function automatic logic [55:0] model_rotl(input logic [55:0] x, input int n);
        return (x << n) | (x >> (56 - n));
    endfunction

    task automatic load_model(input logic [127:0] k, input logic m);
        logic [111:0] p;
        logic [55:0]  c;
        logic [55:0]  d;
        int           cum[16];
        int           acc;
        int           idx;
        p   = model_pc1(k);
        acc = 0;
        for (int r = 0; r < 16; r++) begin
            acc    += sched_tbl[r];
            cum[r] = acc;
        end
        exp_q.delete();
        exp_rnd_q.delete();
        for (int r = 0; r < 16; r++) begin
            idx = m ? 15 - r : r;
            c = model_rotl(p[111:56], cum[idx]);
            d = model_rotl(p[55:0], cum[idx]);
            exp_q.push_back({c[55:8], d[55:8]});
            exp_rnd_q.push_back(4'(r));
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("done_pulse", {127'b0, done}, {127'b0, exp_done});
            if (exp_done) check("valid_after_done", {127'b0, sk_valid}, 128'd0);
            exp_done = 1'b0;
            if (prev_stall) begin
                check("stall_sk_out", {32'b0, sk_out}, {32'b0, prev_sk});
                check("stall_round", {124'b0, sk_round}, {124'b0, prev_rnd});
            end
            if (sk_valid && sk_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_handshake", 128'd1, 128'd0);
                end else begin
                    check("sk_out", {32'b0, sk_out}, {32'b0, exp_q.pop_front()});
                    check("sk_round", {124'b0, sk_round}, {124'b0, exp_rnd_q.pop_front()});
                    got_q.push_back(sk_out);
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end
            prev_stall = sk_valid && !sk_ready;
            prev_sk    = sk_out;
            prev_rnd   = sk_round;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic [127:0] k, input logic m);
        @(posedge clk); #1;
        check("idle_valid", {127'b0, sk_valid}, 128'd0);
        key_in   = k;
        mode     = m;
        sk_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        mode   = ~m;
        check("latency_valid", {127'b0, sk_valid}, 128'd1);
        check("latency_busy", {127'b0, busy}, 128'd1);
        check("latency_round", {124'b0, sk_round}, 128'd0);
    endtask

    task automatic run_stream(input logic [127:0] k, input logic m,
                              input bit rnd_ready, input bit inject_start);
        int cyc;
        bit seen;
        load_model(k, m);
        got_q.delete();
        pulse_start(k, m);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            sk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = inject_start && ($urandom_range(0, 5) == 0);
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        start    = 1'b0;
        sk_ready = 1'b1;
        check("done_timeout", {127'b0, seen}, 128'd1);
        check("stream_drained", 128'(exp_q.size()), 128'd0);
        check("stream_count", 128'(got_q.size()), 128'd16);
        check("busy_after_done", {127'b0, busy}, 128'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] rkey;
        int           cyc;

        // Reset state, checked while reset is held.
        #12;
        check("rst_valid", {127'b0, sk_valid}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, done}, 128'd0);
        check("rst_sk_out", {32'b0, sk_out}, 128'd0);
        check("rst_round", {124'b0, sk_round}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // All-zero key: every subkey is zero.
        load_model('0, 1'b0);
        check("model_zero", {32'b0, exp_q[7]}, 128'd0);
        run_stream('0, 1'b0, 1'b0, 1'b0);

        // All-ones key: every subkey is all ones.
        load_model({128{1'b1}}, 1'b0);
        check("model_ones", {32'b0, exp_q[11]}, {32'b0, {96{1'b1}}});
        run_stream({128{1'b1}}, 1'b0, 1'b0, 1'b0);
        check("ones_dut_r0", {32'b0, got_q[0]}, {32'b0, {96{1'b1}}});

        // Only byte LSBs set: they are parity bits and are dropped.
        load_model({16{8'h01}}, 1'b0);
        check("model_parity", {32'b0, exp_q[3]}, 128'd0);
        run_stream({16{8'h01}}, 1'b0, 1'b0, 1'b0);
        check("parity_dut_r15", {32'b0, got_q[15]}, 128'd0);

        // Single MSB key, encrypt order.
        load_model(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        check("model_msb_r4", {32'b0, exp_q[4]}, 128'd0);
        check("model_msb_r5", {32'b0, exp_q[5]}, {32'b0, 96'h000000000002000000000000});
        run_stream(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        check("msb_dut_r0", {32'b0, got_q[0]}, 128'd0);
        check("msb_dut_r5", {32'b0, got_q[5]}, {32'b0, 96'h000000000002000000000000});
        enc_cap = got_q;

        // Same key, decrypt order: must be the encrypt stream reversed.
        load_model(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
        check("model_dec_r0", {32'b0, exp_q[0]}, {32'b0, 96'h000000080000000000000000});
        run_stream(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        check("dec_dut_r0", {32'b0, got_q[0]}, {32'b0, 96'h000000080000000000000000});
        if (got_q.size() == 16 && enc_cap.size() == 16) begin
            for (int i = 0; i < 16; i++)
                check("dec_reverse", {32'b0, got_q[i]}, {32'b0, enc_cap[15-i]});
        end else begin
            check("dec_reverse_len", 128'(got_q.size()), 128'(enc_cap.size()));
        end

        // Random keys with random backpressure and stray start pulses.
        for (int t = 0; t < 3; t++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_stream(rkey, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        // Asynchronous reset in the middle of a stream, at round 7.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        load_model(rkey, 1'b0);
        got_q.delete();
        pulse_start(rkey, 1'b0);
        cyc = 0;
        while (sk_round != 4'd7 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_round7", {124'b0, sk_round}, 128'd7);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_valid", {127'b0, sk_valid}, 128'd0);
        check("async_busy", {127'b0, busy}, 128'd0);
        check("async_done", {127'b0, done}, 128'd0);
        check("async_sk_out", {32'b0, sk_out}, 128'd0);
        check("async_round", {124'b0, sk_round}, 128'd0);
        exp_q.delete();
        exp_rnd_q.delete();
        exp_done   = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle", {127'b0, sk_valid}, 128'd0);
        end
        mon_en = 1'b1;
        run_stream(rkey, 1'b1, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
